// File: rtl/wb_master_port.sv
// Wishbone classic initiator: single 32-bit reads/writes from a valid/ready
// request channel, with an ack timeout that returns an error response.
module wb_master_port #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          ready_q, ready_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i && ready_q) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = req_we_i;
          sel_d   = req_sel_i;
          adr_d   = req_adr_i;
          dat_d   = req_we_i ? req_dat_i : '0;
          cnt_d   = '0;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (wbm_ack_i) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port: transaction-level model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_wb_master_port;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_adr = '0, req_dat = '0;
  logic        rsp_ready = 1'b1;
  logic        ack = 1'b0;
  logic [31:0] rdat = '0;
  logic        req_ready, rsp_valid, rsp_err, cyc, stb, we;
  logic [31:0] rsp_dat, adr, wdat;
  logic [3:0]  sel;

  int vectors = 0;
  int miscompares = 0;

  wb_master_port #(.TIMEOUT(TIMEOUT), .CW(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_sel_i(req_sel), .req_adr_i(req_adr), .req_dat_i(req_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(wdat),
    .wbm_ack_i(ack), .wbm_dat_i(rdat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending request, one pending response.
  bit          m_busy, m_resp, m_err;
  int          m_waited;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_wdat, m_rdat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_resp <= 0; m_err <= 0; m_waited <= 0;
      m_we <= 0; m_sel <= '0; m_adr <= '0; m_wdat <= '0; m_rdat <= '0;
    end else if (m_busy) begin
      if (ack) begin
        m_busy <= 0; m_resp <= 1; m_err <= 0;
        m_rdat <= m_we ? 32'h0 : rdat;
      end else if (m_waited + 1 >= TIMEOUT) begin
        m_busy <= 0; m_resp <= 1; m_err <= 1; m_rdat <= 32'h0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (m_resp) begin
      if (rsp_ready) begin m_resp <= 0; m_err <= 0; end
    end else if (req_valid) begin
      m_busy <= 1; m_waited <= 0;
      m_we <= req_we; m_sel <= req_sel; m_adr <= req_adr;
      m_wdat <= req_we ? req_dat : 32'h0;
    end
  end

  int stb_run = 0;
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_resp));
    chk("cyc", 32'(cyc), 32'(m_busy));
    chk("stb", 32'(stb), 32'(m_busy));
    chk("we", 32'(we), 32'(m_we));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("adr", adr, m_adr);
    chk("wdat", wdat, m_wdat);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
    chk("rsp_err", 32'(rsp_err), 32'(m_err));
    chk("rsp_dat", rsp_dat, m_rdat);
    stb_run = stb ? stb_run + 1 : 0;
    if (stb) chk("stb_run_bound", 32'(stb_run <= TIMEOUT), 32'd1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    req_we = w; req_sel = s; req_adr = a; req_dat = d; req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
  endtask

  int n_stb;
  bit done;

  initial begin
    // Reset
    step(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    step(1);

    // Write, slave acks in the third stb cycle
    issue(1'b1, 4'hF, 32'h3000_0000, 32'h1234_5678);
    @(negedge clk);
    chk("wr_adr", adr, 32'h3000_0000);
    chk("wr_dat", wdat, 32'h1234_5678);
    chk("wr_sel", 32'(sel), 32'hF);
    chk("wr_we", 32'(we), 32'd1);
    step(2);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    @(negedge clk);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_dat", rsp_dat, 32'h0);
    chk("wr_rsp_err", 32'(rsp_err), 32'd0);
    chk("wr_cyc_low", 32'(cyc), 32'd0);
    step(1);

    // Zero-wait read; ack already high while idle must be ignored
    rdat = 32'hCAFE_F00D;
    ack = 1'b1;
    @(negedge clk);
    chk("stray_ack_idle", 32'(rsp_valid), 32'd0);
    step(1);
    issue(1'b0, 4'hF, 32'h3000_0004, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("rd_stb", 32'(stb), 32'd1);
    chk("rd_wdat_zero", wdat, 32'h0);
    step(1);
    ack = 1'b0;
    @(negedge clk);
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_dat", rsp_dat, 32'hCAFE_F00D);
    step(2);

    // Timeout, no ack
    issue(1'b0, 4'h3, 32'h3000_0008, 32'h0);
    n_stb = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stb) n_stb++;
      if (rsp_valid) done = 1;
    end
    chk("to_finished", 32'(done), 32'd1);
    chk("to_stb_cycles", 32'(n_stb), 32'd16);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_dat", rsp_dat, 32'h0);
    step(2);

    // Ack in the 16th stb cycle wins over the timeout
    rdat = 32'hA5A5_0016;
    issue(1'b0, 4'hF, 32'h3000_000C, 32'h0);
    step(15);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    @(negedge clk);
    chk("late_ack_valid", 32'(rsp_valid), 32'd1);
    chk("late_ack_err", 32'(rsp_err), 32'd0);
    chk("late_ack_dat", rsp_dat, 32'hA5A5_0016);
    step(2);

    // Response backpressure with a second request waiting
    rsp_ready = 1'b0;
    rdat = 32'h1111_2222;
    req_we = 1'b0; req_sel = 4'hF; req_adr = 32'h3000_0010; req_dat = 32'h0;
    req_valid = 1'b1; ack = 1'b1;
    step(1);
    req_we = 1'b1; req_adr = 32'h3000_0014; req_dat = 32'hDEAD_BEEF; req_sel = 4'h5;
    step(1);
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ack = (i == 2);
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_dat", rsp_dat, 32'h1111_2222);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_cyc", 32'(cyc), 32'd0);
      step(1);
    end
    ack = 1'b0;
    rsp_ready = 1'b1;
    step(1);
    @(negedge clk);
    chk("bp_idle_cyc", 32'(cyc), 32'd0);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    step(1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_cyc", 32'(cyc), 32'd1);
    chk("bp_next_adr", adr, 32'h3000_0014);
    chk("bp_next_dat", wdat, 32'hDEAD_BEEF);
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(2);

    // Reset asserted mid-BUS
    issue(1'b1, 4'hF, 32'h3000_0020, 32'h5555_AAAA);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(cyc), 32'd0);
    chk("mid_rst_stb", 32'(stb), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    @(negedge clk);
    chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
